// File: rtl/byte_mem_seq_if.sv
// Request/response bundle for byte_mem_seq: one request channel, one read-response channel.
// Latency: none (wires only).
// Backpressure: req_valid/req_ready on requests, rsp_valid/rsp_ready on read responses.
//
// Signals:
//   req_valid/req_ready  request handshake        req_write  1 = write, 0 = read
//   req_addr             byte address of byte 0   req_wdata  write data, byte i at [8i+7:8i]
//   req_be               per-byte write enables   rsp_*      read response handshake + data
//   busy                 block is not idle
interface byte_mem_seq_if #(
    parameter int W  = 32,
    parameter int AW = 8
);
    localparam int NB = W / 8;

    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  req_wdata;
    logic [NB-1:0] req_be;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_rdata;
    logic          busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/byte_mem_seq.sv
// Byte-addressed little-endian RAM moving one byte per cycle, with byte-enabled partial writes.
// Latency: read response valid NB cycles after accept; write done (req_ready back) NB cycles after accept.
// Backpressure: a read response is held until rsp_ready; no request is accepted outside IDLE.
//
// Ports: clk, rst (synchronous, active-high) and bus (byte_mem_seq_if.slave) carrying the
// request channel, the read-response channel and the busy status.
module byte_mem_seq #(
    parameter int W  = 32,
    parameter int AW = 8
) (
    input  logic           clk,
    input  logic           rst,
    byte_mem_seq_if.slave  bus
);
    localparam int NB    = W / 8;
    localparam int DEPTH = 2 ** AW;
    localparam int CW    = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr_q;
    logic [W-1:0]  wdata_q;
    logic [NB-1:0] be_q;
    logic          write_q;

    logic [7:0]    mem [DEPTH];

    logic [AW-1:0] byte_addr;
    logic [7:0]    wr_byte;
    logic          wr_en_bit;
    logic [7:0]    rd_byte;

    // Address of the byte handled this cycle; the add truncates, giving the modulo-DEPTH wrap.
    assign byte_addr = addr_q + AW'(cnt);
    assign rd_byte   = mem[byte_addr];

    // Select the write-data lane and its enable for the current byte.
    always_comb begin
        wr_byte   = '0;
        wr_en_bit = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (cnt == CW'(i)) begin
                wr_byte   = wdata_q[i*8 +: 8];
                wr_en_bit = be_q[i];
            end
        end
    end

    // Storage is never cleared; a reset edge only suppresses the write on that edge, so bytes
    // already written by an aborted transfer remain.
    always_ff @(posedge clk) begin
        if (!rst && state == XFER && write_q && wr_en_bit) begin
            mem[byte_addr] <= wr_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            write_q       <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q        <= bus.req_addr;
                        wdata_q       <= bus.req_wdata;
                        be_q          <= bus.req_be;
                        write_q       <= bus.req_write;
                        cnt           <= '0;
                        state         <= XFER;
                        bus.req_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                    end
                end
                XFER: begin
                    // Reads assemble the response lane by lane; earlier lanes keep their bytes.
                    if (!write_q) begin
                        for (int i = 0; i < NB; i++) begin
                            if (cnt == CW'(i)) begin
                                bus.rsp_rdata[i*8 +: 8] <= rd_byte;
                            end
                        end
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (write_q) begin
                            state         <= IDLE;
                            bus.req_ready <= 1'b1;
                            bus.busy      <= 1'b0;
                        end else begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    cnt           <= '0;
                    bus.req_ready <= 1'b1;
                    bus.rsp_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_byte_mem_seq.sv
// Self-checking bench for byte_mem_seq (W=32, AW=8): directed vector table, hand-written
// corner sequences (backpressure, ignored request, resets mid-transfer) and random traffic
// checked against a byte-array model of the memory.
module tb_byte_mem_seq;
    localparam int W  = 32;
    localparam int AW = 8;
    localparam int NB = W / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    byte_mem_seq_if #(.W(W), .AW(AW)) bus ();

    byte_mem_seq #(.W(W), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference memory: value per byte plus a flag telling whether it was ever written.
    logic [7:0] ref_mem [256];
    bit         known   [256];

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
        logic [31:0] mask;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp,
                       input logic [31:0] mask = 32'hFFFF_FFFF);
        total++;
        if ((act & mask) !== (exp & mask)) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (mask %h)", name, act, exp, mask);
        end
    endtask

    task automatic model_write(input logic [7:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                ref_mem[(int'(addr) + i) % 256] = wdata[i*8 +: 8];
                known[(int'(addr) + i) % 256]   = 1'b1;
            end
        end
    endtask

    task automatic model_read(input logic [7:0] addr, output logic [31:0] d, output logic [31:0] m);
        d = '0;
        m = '0;
        for (int i = 0; i < NB; i++) begin
            if (known[(int'(addr) + i) % 256]) begin
                d[i*8 +: 8] = ref_mem[(int'(addr) + i) % 256];
                m[i*8 +: 8] = 8'hFF;
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_ready_timeout", 32'(n < 50), 32'd1);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        int n = 0;
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("wr_busy", 32'(bus.busy), 32'd1);
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wr_latency", 32'(n), 32'(NB));
        model_write(addr, wdata, be);
    endtask

    // Issue a read, hold rsp_ready low for 'hold' cycles, optionally presenting a stray write
    // request during the hold (it must be ignored), then accept the response.
    task automatic do_read(input logic [7:0] addr, input int hold, input bit poke, output logic [31:0] data);
        int n = 0;
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = addr;
        bus.req_be    = 4'h0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rd_latency", 32'(n), 32'(NB));
        data = bus.rsp_rdata;
        if (poke) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'b1;
            bus.req_addr  = addr;
            bus.req_wdata = 32'hFFFF_FFFF;
            bus.req_be    = 4'hF;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_rdata", bus.rsp_rdata, data);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_done_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rsp_done_ready", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, e, m;
        int seen;

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'h00;
            known[i]   = 1'b0;
        end

        //             wr    addr   wdata          be    exp            mask
        vecs[0] = '{1'b1, 8'h10, 32'hDDCCBBAA, 4'hF, 32'h0,         32'h0};
        vecs[1] = '{1'b0, 8'h10, 32'h0,        4'h0, 32'hDDCCBBAA,  32'hFFFFFFFF};
        vecs[2] = '{1'b0, 8'h12, 32'h0,        4'h0, 32'h000000CC,  32'h000000FF};
        vecs[3] = '{1'b1, 8'h10, 32'h11223344, 4'h5, 32'h0,         32'h0};
        vecs[4] = '{1'b0, 8'h10, 32'h0,        4'h0, 32'hDD22BB44,  32'hFFFFFFFF};
        vecs[5] = '{1'b1, 8'hFE, 32'h44332211, 4'hF, 32'h0,         32'h0};
        vecs[6] = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h00004433,  32'h0000FFFF};
        vecs[7] = '{1'b0, 8'hFE, 32'h0,        4'h0, 32'h44332211,  32'hFFFFFFFF};
        vecs[8] = '{1'b0, 8'h0F, 32'h0,        4'h0, 32'h22BB4400,  32'hFFFFFF00};

        // Reset held for two edges, outputs checked in the first cycle after release.
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
            end else begin
                do_read(vecs[i].addr, 0, 1'b0, d);
                chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp, vecs[i].mask);
            end
        end

        // Backpressure with a stray write presented during RESP; the stray write must not land.
        do_read(8'h10, 3, 1'b1, d);
        chk("bp_rdata", d, 32'hDD22BB44);
        do_read(8'h10, 0, 1'b0, d);
        chk("ignored_req", d, 32'hDD22BB44);

        // Reset after the second XFER edge of a write: only bytes 0 and 1 land.
        do_write(8'h20, 32'h0000_0000, 4'hF);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h20;
        bus.req_wdata = 32'hA5A5_A5A5;
        bus.req_be    = 4'hF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midwr_busy", 32'(bus.busy), 32'd0);
        chk("midwr_req_ready", 32'(bus.req_ready), 32'd1);
        model_write(8'h20, 32'hA5A5_A5A5, 4'h3);
        do_read(8'h20, 0, 1'b0, d);
        chk("midwr_rdata", d, 32'h0000A5A5);

        // Reset during a read: no response may follow.
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h10;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.rsp_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        chk("midrd_no_rsp", 32'(seen), 32'd0);
        chk("midrd_rdata_cleared", bus.rsp_rdata, 32'd0);
        chk("midrd_req_ready", 32'(bus.req_ready), 32'd1);

        // Random traffic concentrated around the wrap point.
        for (int it = 0; it < 300; it++) begin
            logic [7:0] a;
            a = 8'($urandom_range(0, 39) + 232);
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, $urandom, 4'($urandom_range(0, 15)));
            end else begin
                model_read(a, e, m);
                do_read(a, $urandom_range(0, 2), 1'b0, d);
                if (m != 32'h0) chk("rand_rdata", d, e, m);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/byte_mem_seq.md
Name: byte_mem_seq

Overview:
- Byte-addressed RAM with a parametrised word width and depth, accessed through a valid/ready request port and a valid/ready read-response port.
- Multi-byte words are stored little-endian: byte i of a word lives at address addr+i, wrapping modulo DEPTH.
- One byte moves per cycle, so a W-bit access takes W/8 transfer cycles. Byte enables allow partial writes.
- Sits between a simple master (CPU or test sequencer) and local storage. It is the handshaked, reset-aware successor of the combinational-read byte memory.

Parameters:
- W, 32, data word width in bits; must be a multiple of 8, range 8..64; NB = W/8 bytes per word.
- AW, 8, byte address width; DEPTH = 2**AW bytes.

Ports:
- clk  in  1  clock, all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  AW  byte address of byte 0 of the word.
- req_wdata  in  W  write data; byte i is bits [8i+7:8i].
- req_be  in  NB  byte enables for writes, ignored on reads.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  master accepts the response.
- rsp_rdata  out  W  read data.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset, synchronous, active-high: at a clk edge with rst=1:
  - state goes to IDLE, byte counter to 0;
  - rsp_valid=0, rsp_rdata=0, busy=0;
  - req_ready=1 from the first cycle after reset.
  - Memory array contents are not reset.
  - Reset overrides everything, including mid-transfer. Bytes already written stay written, and the aborted read produces no response.
- States: IDLE, XFER, RESP.
  - IDLE: req_ready=1. On an edge with req_valid=1, latch addr, wdata, be and write, clear the counter and go to XFER.
  - XFER: req_ready=0. At each edge, with a = (addr + cnt) mod DEPTH:
    - if write and be[cnt]=1, mem[a] <= wdata byte cnt;
    - if read, rsp_rdata byte cnt <= mem[a];
    - cnt increments.
    - A disabled byte still consumes its cycle, so latency is fixed.
    - After the edge with cnt=NB-1, go to RESP on a read or to IDLE on a write.
  - RESP: rsp_valid=1 and rsp_rdata stable. On an edge with rsp_ready=1, clear rsp_valid and go to IDLE. No new request is accepted while in RESP.
- Latency, with the request accepted at edge k:
  - read: rsp_valid rises after edge k+NB;
  - write: req_ready rises after edge k+NB, and the data is visible to any subsequently accepted read.
- Throughput: back-to-back writes take NB+1 cycles each. A read takes at least NB+2 cycles, including one RESP cycle with rsp_ready held at 1.
- Address wrap: addr+cnt is computed modulo 2**AW, with no error flag.
- Keep req_valid low when req_ready is low; any request presented then is ignored and is not latched.
- rsp_rdata holds its last value after the response is accepted, until the next read overwrites it byte by byte.
- Reading a never-written location returns an undefined value; the bench must write a location before checking it.

Test Plan (W=32, AW=8):
- Reset: hold rst=1 for 2 cycles, then release → rsp_valid=0, rsp_rdata=0, busy=0, req_ready=1 at the first cycle after release.
- Full write/read: write 0xDDCCBBAA to 0x10 with be=1111, then read 0x10 → rsp_rdata=0xDDCCBBAA. rsp_valid rises exactly 4 cycles after the read accept edge. A byte read of 0x12 (W=8 instance, or check mem[0x12]) returns 0xCC.
- Byte enables: over 0xDDCCBBAA at 0x10, write 0x11223344 with be=0101 → read returns 0xDD22BB44.
- Wrap-around: write 0x44332211 to 0xFE, then read 0x00 → bytes 0x33 and 0x44 appear in bits [15:0], and reading 0xFE returns 0x44332211.
- Backpressure: after a read, hold rsp_ready=0 for 3 cycles → rsp_valid stays 1, rsp_rdata stays constant, req_ready stays 0. Set rsp_ready=1 → rsp_valid=0 and req_ready=1 the next cycle.
- Reset mid-transfer: start a write of 0xA5A5A5A5 to 0x20 over a known 0x00000000, assert rst after the 2nd XFER edge → block returns to IDLE, and reading 0x20 gives 0x0000A5A5.
